// File: rtl/mc_cfg_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_cfg_loader_if
// Brief    : Serial frame handshake and live macrocell XOR config bundle.
// Revision : 1.0
// ============================================================================
interface mc_cfg_loader_if #(
    parameter int NUM_MC = 16
);
    logic              start;
    logic              sdi;
    logic              sdi_valid;
    logic              sdi_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic              cfg_valid;
    logic [NUM_MC-1:0] cfg_xor_a;
    logic [NUM_MC-1:0] cfg_xor_b;
    logic [NUM_MC-1:0] cfg_xor_inv;

    modport master (
        output start, sdi, sdi_valid,
        input  sdi_ready, busy, done, err, cfg_valid,
        input  cfg_xor_a, cfg_xor_b, cfg_xor_inv
    );

    modport slave (
        input  start, sdi, sdi_valid,
        output sdi_ready, busy, done, err, cfg_valid,
        output cfg_xor_a, cfg_xor_b, cfg_xor_inv
    );
endinterface
`default_nettype wire

// File: rtl/mc_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : mc_cfg_loader
// Brief    : Framed serial loader for macrocell xor_a/xor_b/xor_inv selects.
// Revision : 1.0
// ============================================================================
module mc_cfg_loader #(
    parameter int         NUM_MC = 16,
    parameter logic [7:0] SYNC   = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    mc_cfg_loader_if.slave   bus
);
    localparam int                c_PAY_BITS = 3 * NUM_MC;
    localparam int                c_CW       = $clog2(c_PAY_BITS + 1);
    localparam logic [c_CW-1:0]   c_LAST     = c_CW'(c_PAY_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_PAR    = 3'd3,
        ST_COMMIT = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [2:0]             r_hdr_cnt;
    logic [6:0]             r_hdr;
    logic [c_CW-1:0]        r_cnt;
    logic                   r_par;
    logic [c_PAY_BITS-1:0]  r_shadow;
    logic [NUM_MC-1:0]      r_cfg_a, r_cfg_b, r_cfg_inv;
    logic [NUM_MC-1:0]      w_sh_a, w_sh_b, w_sh_inv;
    logic                   r_cfg_valid;
    logic                   w_ready, w_accept, w_hdr_ok, w_par_ok, w_restart;
    logic                   w_busy, w_done, w_err;

    assign w_ready   = (r_state == ST_HDR) || (r_state == ST_LOAD) || (r_state == ST_PAR);
    assign w_accept  = bus.sdi_valid && w_ready;
    // Header compare includes the bit arriving this cycle, so no extra cycle.
    assign w_hdr_ok  = ({r_hdr, bus.sdi} == SYNC);
    assign w_par_ok  = ~(r_par ^ bus.sdi);
    assign w_restart = bus.start && ((r_state == ST_IDLE) || (r_state == ST_ERR));

    // Shadow is packed per macrocell as {inv, b, a}, macrocell 0 at the bottom.
    for (genvar i = 0; i < NUM_MC; i++) begin : g_unpack
        assign w_sh_a[i]   = r_shadow[3*i];
        assign w_sh_b[i]   = r_shadow[3*i+1];
        assign w_sh_inv[i] = r_shadow[3*i+2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_next = ST_HDR;
            end
            ST_HDR: begin
                w_busy = 1'b1;
                if (w_accept && (r_hdr_cnt == 3'd7)) w_next = w_hdr_ok ? ST_LOAD : ST_ERR;
            end
            ST_LOAD: begin
                w_busy = 1'b1;
                if (w_accept && (r_cnt == c_LAST)) w_next = ST_PAR;
            end
            ST_PAR: begin
                w_busy = 1'b1;
                if (w_accept) w_next = w_par_ok ? ST_COMMIT : ST_ERR;
            end
            ST_COMMIT: begin
                w_busy = 1'b1;
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            ST_ERR: begin
                w_err = 1'b1;
                if (bus.start) w_next = ST_HDR;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hdr_cnt   <= '0;
            r_hdr       <= '0;
            r_cnt       <= '0;
            r_par       <= 1'b0;
            r_shadow    <= '0;
            r_cfg_a     <= '0;
            r_cfg_b     <= '0;
            r_cfg_inv   <= '0;
            r_cfg_valid <= 1'b0;
        end else begin
            if (w_restart) begin
                r_hdr_cnt <= '0;
                r_cnt     <= '0;
                r_par     <= 1'b0;
            end
            if (w_accept && (r_state == ST_HDR)) begin
                r_hdr     <= {r_hdr[5:0], bus.sdi};
                r_hdr_cnt <= r_hdr_cnt + 3'd1;
            end
            if (w_accept && (r_state == ST_LOAD)) begin
                r_shadow[r_cnt] <= bus.sdi;
                r_par           <= r_par ^ bus.sdi;
                r_cnt           <= r_cnt + c_CW'(1);
            end
            if (r_state == ST_COMMIT) begin
                r_cfg_a     <= w_sh_a;
                r_cfg_b     <= w_sh_b;
                r_cfg_inv   <= w_sh_inv;
                r_cfg_valid <= 1'b1;
            end
        end
    end

    assign bus.sdi_ready   = w_ready;
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.err         = w_err;
    assign bus.cfg_valid   = r_cfg_valid;
    assign bus.cfg_xor_a   = r_cfg_a;
    assign bus.cfg_xor_b   = r_cfg_b;
    assign bus.cfg_xor_inv = r_cfg_inv;
endmodule
`default_nettype wire

// File: tb/tb_mc_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_cfg_loader
// Brief    : Self-checking bench for mc_cfg_loader (NUM_MC = 2).
// Revision : 1.0
// ============================================================================
module tb_mc_cfg_loader;
    localparam int N  = 2;
    localparam int PB = 3 * N;

    typedef struct {
        logic [7:0]    hdr;
        logic [PB-1:0] pay;
        logic          par;
        int            gmode;
        bit            inject;
        logic [N-1:0]  ea;
        logic [N-1:0]  eb;
        logic [N-1:0]  einv;
        logic          eerr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mc_cfg_loader_if #(.NUM_MC(N)) bus ();
    mc_cfg_loader #(.NUM_MC(N), .SYNC(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int           n_checks = 0;
    int           n_errors = 0;
    logic [N-1:0] m_a, m_b, m_inv;
    logic         m_valid;
    vec_t         tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int gap_for(input int gmode, input bit first);
        if (gmode == 1) return first ? 0 : 2;
        if (gmode == 2) return int'($urandom_range(0, 3));
        return 0;
    endfunction

    task automatic do_start;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.sdi_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gaps, input bit inject, output bit ok);
        for (int g = 0; g < gaps; g++) begin
            @(negedge clk);
            bus.sdi_valid = 1'b0;
            bus.start     = inject;
        end
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            bus.start     = 1'b0;
            bus.sdi       = b;
            bus.sdi_valid = 1'b1;
            ok            = bus.sdi_ready;
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
    endtask

    // Spec-level outcome: frame commits iff header matches and total parity is even.
    task automatic run_frame(input logic [7:0] hdr, input logic [PB-1:0] pay, input logic par,
                             input int gmode, input bit inject);
        bit ok;
        bit hdr_ok;
        bit good;
        hdr_ok = (hdr == 8'hA5);
        good   = hdr_ok && ((^pay ^ par) == 1'b0);
        do_start;
        for (int k = 0; k < 8; k++) begin
            send_bit(hdr[7-k], gap_for(gmode, k == 0), 1'b0, ok);
            if (!ok) return;
        end
        if (hdr_ok) begin
            for (int k = 0; k < PB; k++) begin
                send_bit(pay[k], gap_for(gmode, 1'b0), inject, ok);
                if (!ok) return;
            end
            send_bit(par, gap_for(gmode, 1'b0), 1'b0, ok);
            if (!ok) return;
        end
        @(negedge clk);
        bus.sdi_valid = 1'b0;
        bus.start     = 1'b0;
        check("done_pulse", bus.done, good);
        check("err_after_frame", bus.err, !good);
        check("busy_after_frame", bus.busy, good);
        check("ready_after_frame", bus.sdi_ready, 1'b0);
        check("cfg_a_not_early", bus.cfg_xor_a, m_a);
        if (good) begin
            for (int i = 0; i < N; i++) begin
                m_a[i]   = pay[3*i];
                m_b[i]   = pay[3*i+1];
                m_inv[i] = pay[3*i+2];
            end
            m_valid = 1'b1;
        end
        @(negedge clk);
        check("done_single", bus.done, 1'b0);
        check("err_held", bus.err, !good);
        check("busy_idle", bus.busy, 1'b0);
        check("cfg_a", bus.cfg_xor_a, m_a);
        check("cfg_b", bus.cfg_xor_b, m_b);
        check("cfg_inv", bus.cfg_xor_inv, m_inv);
        check("cfg_valid", bus.cfg_valid, m_valid);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.sdi       = 1'b0;
        bus.sdi_valid = 1'b0;
        m_a = '0; m_b = '0; m_inv = '0; m_valid = 1'b0;

        //            hdr    pay        par  gm inj  a      b      inv    err
        tbl[0] = '{8'hA5, 6'b110101, 1'b0, 0, 0, 2'b01, 2'b10, 2'b11, 1'b0};
        tbl[1] = '{8'hA4, 6'b110101, 1'b0, 0, 0, 2'b01, 2'b10, 2'b11, 1'b1};
        tbl[2] = '{8'hA5, 6'b110101, 1'b1, 0, 0, 2'b01, 2'b10, 2'b11, 1'b1};
        tbl[3] = '{8'hA5, 6'b111111, 1'b0, 0, 0, 2'b11, 2'b11, 2'b11, 1'b0};
        tbl[4] = '{8'hA5, 6'b110101, 1'b0, 1, 1, 2'b01, 2'b10, 2'b11, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_cfg_a", bus.cfg_xor_a, 0);
        check("rst_cfg_b", bus.cfg_xor_b, 0);
        check("rst_cfg_inv", bus.cfg_xor_inv, 0);
        check("rst_cfg_valid", bus.cfg_valid, 0);
        check("rst_ready", bus.sdi_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);

        for (int v = 0; v < 5; v++) begin
            run_frame(tbl[v].hdr, tbl[v].pay, tbl[v].par, tbl[v].gmode, tbl[v].inject);
            check("tbl_cfg_a", bus.cfg_xor_a, tbl[v].ea);
            check("tbl_cfg_b", bus.cfg_xor_b, tbl[v].eb);
            check("tbl_cfg_inv", bus.cfg_xor_inv, tbl[v].einv);
            check("tbl_err", bus.err, tbl[v].eerr);
            check("tbl_cfg_valid", bus.cfg_valid, 1'b1);
        end

        // Asynchronous reset between clock edges, mid-payload.
        do_start;
        for (int k = 0; k < 8; k++) send_bit(((8'hA5 >> (7 - k)) & 8'h1) != 0, 0, 1'b0, ok);
        for (int k = 0; k < 3; k++) send_bit(1'b1, 0, 1'b0, ok);
        #2 rst = 1'b1;
        #1;
        check("arst_cfg_a", bus.cfg_xor_a, 0);
        check("arst_cfg_b", bus.cfg_xor_b, 0);
        check("arst_cfg_inv", bus.cfg_xor_inv, 0);
        check("arst_cfg_valid", bus.cfg_valid, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_ready", bus.sdi_ready, 0);
        m_a = '0; m_b = '0; m_inv = '0; m_valid = 1'b0;
        @(negedge clk);
        bus.sdi_valid = 1'b0;
        rst = 1'b0;
        run_frame(8'hA5, 6'b110101, 1'b0, 0, 1'b0);
        check("post_rst_cfg_a", bus.cfg_xor_a, 2'b01);
        check("post_rst_cfg_inv", bus.cfg_xor_inv, 2'b11);

        for (int r = 0; r < 30; r++) begin
            logic [7:0]    hdr;
            logic [PB-1:0] pay;
            hdr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hA5;
            pay = PB'($urandom);
            run_frame(hdr, pay, 1'($urandom), 2, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
